// File: rtl/jtframe_sdm_nch_if.sv
// jtframe_sdm_nch_if: sound samples, mute request and DAC outputs of the sigma-delta block.
interface jtframe_sdm_nch_if #(
    parameter int CHANNELS = 2,
    parameter int DW       = 16
);
    logic [CHANNELS*DW-1:0] snd;
    logic                   mute;
    logic [CHANNELS-1:0]    pwm;
    logic                   cen_dac;
    logic                   muted;

    modport master (
        output snd,
        output mute,
        input  pwm,
        input  cen_dac,
        input  muted
    );

    modport slave (
        input  snd,
        input  mute,
        output pwm,
        output cen_dac,
        output muted
    );
endinterface

// File: rtl/jtframe_sdm_nch.sv
// jtframe_sdm_nch: N-channel 1-bit sigma-delta audio DAC.
// A clock-enable divider paces all channels. A shared gain ramps between 0 and
// unity for click-free mute and soft start. Each channel runs either a
// first-order (carry-out) or a second-order (two integrator) modulator.
module jtframe_sdm_nch #(
    parameter int CHANNELS   = 2,
    parameter int DW         = 16,
    parameter bit SIGNED_SND = 1'b0,
    parameter int ORDER      = 1,
    parameter int CEN_DIV    = 4,
    parameter int GW         = 6,
    parameter int RAMP_SH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    jtframe_sdm_nch_if.slave bus
);
    localparam int            CW       = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
    localparam int            PW       = (RAMP_SH > 0) ? RAMP_SH : 1;
    localparam int            IW       = DW + 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);
    localparam logic [GW:0]   UNITY    = {1'b1, {GW{1'b0}}};

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("jtframe_sdm_nch: ORDER must be 1 or 2");
    end

    // Two's complement samples become offset-binary by flipping the MSB
    function automatic logic [DW-1:0] to_offset(input logic [DW-1:0] s);
        return {s[DW-1] ^ SIGNED_SND, s[DW-2:0]};
    endfunction

    // Truncating fixed-point gain; unity gain passes u through unchanged
    function automatic logic [DW-1:0] apply_gain(input logic [DW-1:0] u,
                                                 input logic [GW:0]   g);
        logic [DW+GW:0] prod;
        prod = {{(GW+1){1'b0}}, u} * {{DW{1'b0}}, g};
        return DW'(prod >> GW);
    endfunction

    // One gain step toward the target, saturating at 0 and at unity
    function automatic logic [GW:0] gain_step(input logic [GW:0] g,
                                              input logic        down);
        if (down) begin
            return (g == '0) ? g : g - 1'b1;
        end
        return (g == UNITY) ? g : g + 1'b1;
    endfunction

    logic [CW-1:0]       cnt;
    logic                vld_p0;
    logic [PW-1:0]       pre;
    logic [GW:0]         gain;
    logic                muted_r;
    logic                pre_wrap;
    logic [GW:0]         gain_nx;
    logic [CHANNELS-1:0] pwm_vec;

    // Free-running divider; the update strobe follows the last count by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (cnt == CNT_LAST);
            cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign pre_wrap = (RAMP_SH == 0) || (pre == {PW{1'b1}});
    assign gain_nx  = pre_wrap ? gain_step(gain, bus.mute) : gain;

    // Gain ramp: prescaler counts updates, gain moves one step on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            gain    <= '0;
            muted_r <= 1'b1;
        end else if (vld_p0) begin
            pre     <= (RAMP_SH == 0) ? '0 : pre + 1'b1;
            gain    <= gain_nx;
            muted_r <= (gain_nx == '0);
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DW-1:0] u_p0;
        logic [DW-1:0] x_p0;
        logic          pwm_p1;

        assign u_p0       = to_offset(bus.snd[k*DW +: DW]);
        assign x_p0       = apply_gain(u_p0, gain);
        assign pwm_vec[k] = pwm_p1;

        if (ORDER == 2) begin : g_o2
            logic signed [IW-1:0] i1_p1;
            logic signed [IW-1:0] i2_p1;
            logic signed [IW-1:0] xs_p0;
            logic signed [IW-1:0] y_p0;
            logic signed [IW-1:0] i1n_p0;
            logic signed [IW-1:0] i2n_p0;

            assign xs_p0  = $signed({4'b0000, x_p0});
            assign y_p0   = pwm_p1 ? $signed({4'b0000, {DW{1'b1}}}) : '0;
            assign i1n_p0 = i1_p1 + xs_p0 - y_p0;
            assign i2n_p0 = i2_p1 + i1n_p0 - y_p0;

            // Two cascaded integrators, full-scale feedback into both, sign-bit quantiser
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1_p1  <= '0;
                    i2_p1  <= '0;
                    pwm_p1 <= 1'b0;
                end else if (vld_p0) begin
                    i1_p1  <= i1n_p0;
                    i2_p1  <= i2n_p0;
                    pwm_p1 <= ~i2n_p0[IW-1];
                end
            end
        end else begin : g_o1
            logic [DW-1:0] acc_p1;
            logic [DW:0]   sum_p0;

            assign sum_p0 = {1'b0, acc_p1} + {1'b0, x_p0};

            // Phase accumulator; its carry out is the 1-bit output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_p1 <= '0;
                    pwm_p1 <= 1'b0;
                end else if (vld_p0) begin
                    acc_p1 <= sum_p0[DW-1:0];
                    pwm_p1 <= sum_p0[DW];
                end
            end
        end
    end

    assign bus.pwm     = pwm_vec;
    assign bus.cen_dac = vld_p0;
    assign bus.muted   = muted_r;

endmodule

// File: tb/tb_jtframe_sdm_nch.sv
// tb_jtframe_sdm_nch: three DAC instances (order 1 offset-binary, order 1 signed,
// order 2) driven together and compared every clock against an arithmetic model.
module tb_jtframe_sdm_nch;
    localparam int DW      = 16;
    localparam int GW      = 6;
    localparam int RAMP_SH = 4;
    localparam int CEN_DIV = 4;
    localparam int UNITY   = 1 << GW;
    localparam int FS      = (1 << DW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          mute  = 1'b0;
    logic [DW-1:0] su1 [2];
    logic [DW-1:0] ss1;
    logic [DW-1:0] so2 [2];

    jtframe_sdm_nch_if #(.CHANNELS(2), .DW(DW)) bus_u1 ();
    jtframe_sdm_nch_if #(.CHANNELS(1), .DW(DW)) bus_s1 ();
    jtframe_sdm_nch_if #(.CHANNELS(2), .DW(DW)) bus_o2 ();

    assign bus_u1.snd  = {su1[1], su1[0]};
    assign bus_u1.mute = mute;
    assign bus_s1.snd  = ss1;
    assign bus_s1.mute = mute;
    assign bus_o2.snd  = {so2[1], so2[0]};
    assign bus_o2.mute = mute;

    jtframe_sdm_nch #(.CHANNELS(2), .DW(DW), .SIGNED_SND(1'b0), .ORDER(1),
                      .CEN_DIV(CEN_DIV), .GW(GW), .RAMP_SH(RAMP_SH))
        u_u1 (.clk(clk), .rst_n(rst_n), .bus(bus_u1));
    jtframe_sdm_nch #(.CHANNELS(1), .DW(DW), .SIGNED_SND(1'b1), .ORDER(1),
                      .CEN_DIV(CEN_DIV), .GW(GW), .RAMP_SH(RAMP_SH))
        u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));
    jtframe_sdm_nch #(.CHANNELS(2), .DW(DW), .SIGNED_SND(1'b0), .ORDER(2),
                      .CEN_DIV(CEN_DIV), .GW(GW), .RAMP_SH(RAMP_SH))
        u_o2 (.clk(clk), .rst_n(rst_n), .bus(bus_o2));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: plain integers, advanced once per modulator update
    int m_gain, m_updates, m_edge;
    bit m_cen;
    int acc_u1 [2];
    int acc_s1;
    int i1 [2];
    int i2 [2];
    bit mp_u1 [2];
    bit mp_s1;
    bit mp_o2 [2];
    bit track_i2;
    int i2_max;
    bit rnd_mode;
    int dut_dg_max;
    int prev_dut_gain;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int wrap_iw(input int v);
        logic signed [DW+3:0] t;
        t = v[DW+3:0];
        return int'(t);
    endfunction

    task automatic model_reset();
        m_gain = 0; m_updates = 0; m_edge = 0; m_cen = 1'b0;
        acc_s1 = 0; mp_s1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            acc_u1[c] = 0; i1[c] = 0; i2[c] = 0;
            mp_u1[c] = 1'b0; mp_o2[c] = 1'b0;
        end
    endtask

    task automatic model_update();
        int x, s, y, u, a;
        for (int c = 0; c < 2; c++) begin
            x = (int'(su1[c]) * m_gain) / UNITY;
            s = acc_u1[c] + x;
            mp_u1[c] = (s > FS);
            acc_u1[c] = s % (FS + 1);
        end
        u = int'(ss1) ^ (1 << (DW - 1));
        x = (u * m_gain) / UNITY;
        s = acc_s1 + x;
        mp_s1 = (s > FS);
        acc_s1 = s % (FS + 1);
        for (int c = 0; c < 2; c++) begin
            x = (int'(so2[c]) * m_gain) / UNITY;
            y = mp_o2[c] ? FS : 0;
            i1[c] = wrap_iw(i1[c] + x - y);
            i2[c] = wrap_iw(i2[c] + i1[c] - y);
            mp_o2[c] = (i2[c] >= 0);
            a = (i2[c] < 0) ? -i2[c] : i2[c];
            if (track_i2 && a > i2_max) i2_max = a;
        end
        m_updates++;
        if (m_updates % (1 << RAMP_SH) == 0) begin
            if (mute) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
            else      m_gain = (m_gain < UNITY) ? m_gain + 1 : UNITY;
        end
    endtask

    task automatic randomize_snd();
        for (int c = 0; c < 2; c++) begin
            su1[c] = DW'($urandom);
            so2[c] = DW'($urandom_range(32'hEFFF, 32'h1000));
        end
        ss1 = DW'($urandom);
    endtask

    // One clock: advance the model, compare every output at the falling edge
    task automatic step();
        int g, d;
        @(negedge clk);
        m_edge++;
        if (m_cen) model_update();
        m_cen = (m_edge % CEN_DIV == 0);
        check("cen_u1", bus_u1.cen_dac, m_cen);
        check("cen_s1", bus_s1.cen_dac, m_cen);
        check("cen_o2", bus_o2.cen_dac, m_cen);
        check("pwm_u1", bus_u1.pwm, {mp_u1[1], mp_u1[0]});
        check("pwm_s1", bus_s1.pwm, mp_s1);
        check("pwm_o2", bus_o2.pwm, {mp_o2[1], mp_o2[0]});
        check("muted_u1", bus_u1.muted, (m_gain == 0));
        check("muted_s1", bus_s1.muted, (m_gain == 0));
        check("muted_o2", bus_o2.muted, (m_gain == 0));
        g = int'(u_u1.gain);
        check("gain_u1", g, m_gain);
        d = g - prev_dut_gain;
        if (d < 0) d = -d;
        if (d > dut_dg_max) dut_dg_max = d;
        prev_dut_gain = g;
        if (rnd_mode) randomize_snd();
    endtask

    task automatic run_updates(input int n);
        int target, guard;
        target = m_updates + n;
        guard = 0;
        while (m_updates < target && guard < n * CEN_DIV + 16) begin
            step();
            guard++;
        end
        if (m_updates < target) check("run_updates_timeout", m_updates, target);
    endtask

    task automatic run_until_gain(input int target, input int max_upd, input string tag);
        int start;
        start = m_updates;
        while (m_gain != target && m_updates - start < max_upd) step();
        check(tag, m_gain, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_unmute, ones_a, ones_b, zeros_s, o0, o1, guard;
        logic prev_u, prev_s, want_u, want_s;

        model_reset();
        track_i2 = 1'b0; i2_max = 0; dut_dg_max = 0; prev_dut_gain = 0;
        rnd_mode = 1'b1;
        randomize_snd();
        mute  = 1'b0;
        rst_n = 1'b0;

        // Held in reset: outputs at their reset values
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm_u1", bus_u1.pwm, 0);
            check("rst_pwm_o2", bus_o2.pwm, 0);
            check("rst_muted", bus_u1.muted, 1);
            check("rst_cen", bus_u1.cen_dac, 0);
        end
        rst_n = 1'b1;

        // Soft start from reset with random programme material
        first_unmute = -1;
        guard = 0;
        while (m_updates < 1024 && guard < 1024 * CEN_DIV + 32) begin
            step();
            guard++;
            if (first_unmute < 0 && bus_u1.muted == 1'b0) first_unmute = m_updates;
        end
        check("muted_fall_update", first_unmute, 16);
        check("gain_after_1024", u_u1.gain, UNITY);

        // Midscale: offset-binary 0x8000 and signed 0x0000 both alternate
        rnd_mode = 1'b0;
        su1[0] = 16'h8000; su1[1] = 16'h1234;
        ss1    = 16'h0000;
        so2[0] = 16'h2000; so2[1] = 16'hC000;
        run_updates(4);
        prev_u = bus_u1.pwm[0];
        prev_s = bus_s1.pwm[0];
        for (int i = 0; i < 8; i++) begin
            run_updates(1);
            want_u = !prev_u;
            want_s = !prev_s;
            check("mid_alt_u1", bus_u1.pwm[0], want_u);
            check("mid_alt_s1", bus_s1.pwm[0], want_s);
            prev_u = bus_u1.pwm[0];
            prev_s = bus_s1.pwm[0];
        end

        // First-order densities: quarter scale, zero, full scale
        su1[0] = 16'h4000; su1[1] = 16'h0000;
        ss1    = 16'h7FFF;
        ones_a = 0; ones_b = 0; zeros_s = 0;
        for (int i = 0; i < 1024; i++) begin
            run_updates(1);
            ones_a += int'(bus_u1.pwm[0]);
            ones_b += int'(bus_u1.pwm[1]);
            zeros_s += int'(!bus_s1.pwm[0]);
        end
        check("o1_ones_4000", ones_a, 256);
        check("o1_ones_0000", ones_b, 0);
        check("o1_zeros_ffff_le1", (zeros_s <= 1), 1);

        // Second-order densities over 4096 updates
        track_i2 = 1'b1; i2_max = 0;
        o0 = 0; o1 = 0;
        for (int i = 0; i < 4096; i++) begin
            run_updates(1);
            o0 += int'(bus_o2.pwm[0]);
            o1 += int'(bus_o2.pwm[1]);
        end
        track_i2 = 1'b0;
        check("o2_ones_2000_in_510_514", (o0 >= 510 && o0 <= 514), 1);
        check("o2_ones_c000_in_3070_3074", (o1 >= 3070 && o1 <= 3074), 1);
        check("o2_i2_bound", (i2_max < (1 << (DW + 2))), 1);

        // Mute reversal mid-ramp, then mute to completion
        rnd_mode = 1'b1;
        check("gain_before_mute", u_u1.gain, UNITY);
        dut_dg_max = 0;
        prev_dut_gain = int'(u_u1.gain);
        mute = 1'b1;
        run_until_gain(40, 24 * 16 + 8, "ramp_down_to_40");
        mute = 1'b0;
        run_until_gain(UNITY, 24 * 16 + 8, "ramp_back_to_64");
        check("gain_max_step", dut_dg_max, 1);
        mute = 1'b1;
        run_until_gain(0, UNITY * 16 + 8, "ramp_down_to_0");
        ones_a = 0;
        for (int i = 0; i < 64; i++) begin
            run_updates(1);
            ones_a += int'(bus_u1.pwm[0]) + int'(bus_u1.pwm[1]) + int'(bus_s1.pwm[0]);
        end
        check("muted_pwm_ones", ones_a, 0);
        check("muted_final", bus_u1.muted, 1);

        // Asynchronous reset while running at unity gain
        mute = 1'b0;
        run_until_gain(UNITY, UNITY * 16 + 8, "reramp_to_64");
        rnd_mode = 1'b0;
        su1[0] = 16'h8000; su1[1] = 16'hFFFF;
        run_updates(3);
        guard = 0;
        while (!m_cen && guard < 2 * CEN_DIV) begin
            step();
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pwm_u1", bus_u1.pwm, 0);
        check("async_pwm_o2", bus_o2.pwm, 0);
        check("async_cen", bus_u1.cen_dac, 0);
        check("async_muted", bus_u1.muted, 1);
        check("async_gain", u_u1.gain, 0);
        model_reset();
        prev_dut_gain = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rnd_mode = 1'b1;
        run_updates(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
